// File: rtl/find_global_bkt_lvl.sv
// Global backtrack-level finder: walks the per-level decision table down from the current
// level to the highest level whose other polarity is still untried.
module find_global_bkt_lvl #(
  parameter int unsigned WIDTH_BIN_ID   = 10,
  parameter int unsigned WIDTH_LVL      = 16,
  parameter int unsigned WIDTH_LVL_ADDR = 9,
  parameter int unsigned MAX_LVL        = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_find_i,
  input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
  output logic                    done_find_o,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
  output logic                    busy_o,
  input  logic                    lvl_wr_en_i,
  input  logic [WIDTH_LVL-1:0]    lvl_wr_lvl_i,
  input  logic [WIDTH_BIN_ID-1:0] lvl_wr_bin_i,
  input  logic                    lvl_wr_flip_i,
  input  logic                    clr_i
);

  typedef enum logic [1:0] {StIdle, StSearch, StClear, StDone} state_e;

  localparam logic [WIDTH_LVL_ADDR-1:0] LastIdx = WIDTH_LVL_ADDR'(MAX_LVL - 1);

  state_e                    state_q;
  logic [WIDTH_LVL_ADDR-1:0] idx_q;

  logic [WIDTH_BIN_ID-1:0]   tbl_bin  [MAX_LVL];
  logic                      tbl_flip [MAX_LVL];

  logic [WIDTH_BIN_ID-1:0]   rd_bin;
  logic                      rd_flip;
  logic [WIDTH_LVL_ADDR-1:0] start_idx;
  logic                      wr_in_range;
  logic [WIDTH_LVL_ADDR-1:0] wr_addr;

  assign rd_bin  = tbl_bin[idx_q];
  assign rd_flip = tbl_flip[idx_q];

  // Levels beyond the table are clamped to the top entry.
  assign start_idx = (cur_lvl_i > WIDTH_LVL'(MAX_LVL - 1)) ? LastIdx
                                                           : cur_lvl_i[WIDTH_LVL_ADDR-1:0];

  assign wr_in_range = (lvl_wr_lvl_i < WIDTH_LVL'(MAX_LVL));
  assign wr_addr     = lvl_wr_lvl_i[WIDTH_LVL_ADDR-1:0];

  assign busy_o = (state_q == StSearch) || (state_q == StClear);

  // Table is deliberately not reset; clr_i sweeps it. An external write in the same
  // cycle as a clear sweep of the same entry wins.
  always_ff @(posedge clk) begin
    if (rst && (state_q == StClear)) begin
      tbl_bin[idx_q]  <= '0;
      tbl_flip[idx_q] <= 1'b0;
    end
    if (lvl_wr_en_i && wr_in_range) begin
      tbl_bin[wr_addr]  <= lvl_wr_bin_i;
      tbl_flip[wr_addr] <= lvl_wr_flip_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      done_find_o <= 1'b0;
      bkt_lvl_o   <= '0;
      bkt_bin_o   <= '0;
    end else begin
      done_find_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_i) begin
            state_q <= StClear;
            idx_q   <= '0;
          end else if (start_find_i) begin
            state_q <= StSearch;
            idx_q   <= start_idx;
          end
        end
        StSearch: begin
          // Level 0 is never a candidate: reaching it means global UNSAT.
          if (idx_q == '0) begin
            state_q   <= StDone;
            bkt_lvl_o <= '0;
            bkt_bin_o <= '0;
          end else if (!rd_flip) begin
            state_q   <= StDone;
            bkt_lvl_o <= WIDTH_LVL'(idx_q);
            bkt_bin_o <= rd_bin;
          end else begin
            idx_q <= idx_q - WIDTH_LVL_ADDR'(1);
          end
        end
        StClear: begin
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q + WIDTH_LVL_ADDR'(1);
          end
        end
        StDone: begin
          done_find_o <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
